// File: rtl/rf_debug_port.sv
// Debug access engine for the register file: dumps every register to a valid/ready
// stream, or loads every register from one, while BUSY stalls the core.
module rf_debug_port #(
  parameter int AWL = 5,
  parameter int WL  = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic           MODE,
  output logic           BUSY,
  output logic           DONE,
  output logic           DOUT_VALID,
  input  logic           DOUT_READY,
  output logic [WL-1:0]  DOUT_DATA,
  output logic [AWL-1:0] DOUT_ADDR,
  input  logic           DIN_VALID,
  output logic           DIN_READY,
  input  logic [WL-1:0]  DIN_DATA,
  output logic [AWL-1:0] RFRA,
  input  logic [WL-1:0]  RFRD,
  output logic           RFWE,
  output logic [AWL-1:0] RFWA,
  output logic [WL-1:0]  RFWD
);

  localparam logic [AWL-1:0] LAST_ADDR = '1;
  localparam logic [AWL-1:0] ADDR_ONE  = AWL'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DUMP_RD  = 3'd1,
    DUMP_OUT = 3'd2,
    LOAD     = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t         state_reg, state_next;
  logic [AWL-1:0] addr_reg, addr_next;
  logic [WL-1:0]  dout_data_reg, dout_data_next;
  logic [AWL-1:0] dout_addr_reg, dout_addr_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      dout_data_reg <= '0;
      dout_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      dout_data_reg <= dout_data_next;
      dout_addr_reg <= dout_addr_next;
    end
  end

  // The terminal-address check comes before the increment, so ADDR never wraps mid-operation.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    dout_data_next = dout_data_reg;
    dout_addr_next = dout_addr_reg;
    case (state_reg)
      IDLE: begin
        addr_next = '0;
        if (START) begin
          state_next = MODE ? LOAD : DUMP_RD;
        end
      end
      DUMP_RD: begin
        dout_data_next = RFRD;
        dout_addr_next = addr_reg;
        state_next     = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (DOUT_READY) begin
          if (addr_reg == LAST_ADDR) begin
            state_next = FINISH;
          end else begin
            addr_next  = addr_reg + ADDR_ONE;
            state_next = DUMP_RD;
          end
        end
      end
      LOAD: begin
        if (DIN_VALID) begin
          if (addr_reg == LAST_ADDR) begin
            state_next = FINISH;
          end else begin
            addr_next = addr_reg + ADDR_ONE;
          end
        end
      end
      FINISH: begin
        addr_next  = '0;
        state_next = IDLE;
      end
      default: begin
        addr_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Write-port signals are combinational so a load word lands on its handshake edge.
  always_comb begin
    BUSY       = (state_reg != IDLE);
    DONE       = (state_reg == FINISH);
    DOUT_VALID = (state_reg == DUMP_OUT);
    DIN_READY  = (state_reg == LOAD);
    RFRA       = addr_reg;
    RFWA       = addr_reg;
    RFWE       = 1'b0;
    RFWD       = '0;
    if (state_reg == LOAD) begin
      RFWE = DIN_VALID;
      RFWD = DIN_DATA;
    end
  end

  assign DOUT_DATA = dout_data_reg;
  assign DOUT_ADDR = dout_addr_reg;

endmodule
